// File: rtl/fp_divider.sv
// Sequential binary32 divider: radix-2 restoring mantissa loop,
// start/busy/done handshake, fixed latency with a one-cycle special path.
module fp_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  round_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] resultDiv,
  output logic        errorDiv,
  output logic        overflowDiv
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND
  } state_t;

  state_t state_q, state_d;

  logic [30:0] a_q, b_q;
  logic [1:0]  rm_q;
  logic        sign_q;
  logic [5:0]  cnt_q;
  logic [23:0] rem_q;
  logic [25:0] q_q;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        zero_a, zero_b;
  logic        inv, dz, ia, zr, special;

  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign fa = a_q[22:0];
  assign fb = b_q[22:0];

  assign nan_a  = (ea == 8'hFF) & (fa != '0);
  assign nan_b  = (eb == 8'hFF) & (fb != '0);
  assign inf_a  = (ea == 8'hFF) & (fa == '0);
  assign inf_b  = (eb == 8'hFF) & (fb == '0);
  // E=0 covers both true zero and flushed subnormals
  assign zero_a = (ea == 8'h00);
  assign zero_b = (eb == 8'h00);

  // priority-resolved so that at most one class is active
  assign inv = nan_a | nan_b
             | (zero_a & zero_b)
             | (inf_a & inf_b);
  assign dz  = ~inv & zero_b & ~inf_a;
  assign ia  = ~inv & inf_a;
  assign zr  = ~inv & ~dz & ~ia
             & (zero_a | inf_b);
  assign special = inv | dz | ia | zr;

  logic [31:0] spec_res;
  logic        spec_err;

  always_comb begin
    spec_res = '0;
    spec_err = 1'b0;
    unique case (1'b1)
      inv: begin
        spec_res = {sign_q, 8'hFF, 23'h400000};
        spec_err = 1'b1;
      end
      dz: begin
        spec_res = {sign_q, 8'hFF, 23'h0};
        spec_err = 1'b1;
      end
      ia: spec_res = {sign_q, 8'hFF, 23'h0};
      default: spec_res = {sign_q, 31'h0};
    endcase
  end

  logic [23:0] m1, m2;
  logic [24:0] rem_in;
  logic [24:0] rem_sub;
  logic        ge;
  logic [23:0] rem_nx;
  logic [25:0] q_nx;

  assign m1 = {1'b1, fa};
  assign m2 = {1'b1, fb};

  // first step compares M1 unshifted, so q[25] is the integer bit
  assign rem_in  = (cnt_q == 6'd0) ? {1'b0, m1}
                                   : {rem_q, 1'b0};
  assign ge      = rem_in >= {1'b0, m2};
  assign rem_sub = rem_in - {1'b0, m2};
  assign rem_nx  = ge ? rem_sub[23:0] : rem_in[23:0];
  assign q_nx    = {q_q[24:0], ge};

  logic signed [9:0] e_raw, e_norm, e_fin;
  logic [23:0] mant, mant_r;
  logic        rb, st, inc;
  logic [24:0] sum;
  logic [31:0] rnd_res;
  logic        rnd_ovf;

  assign e_raw = $signed({2'b00, ea})
               - $signed({2'b00, eb})
               + 10'sd127;

  always_comb begin
    if (q_q[25]) begin
      mant   = q_q[25:2];
      rb     = q_q[1];
      st     = q_q[0] | (rem_q != '0);
      e_norm = e_raw;
    end else begin
      mant   = q_q[24:1];
      rb     = q_q[0];
      st     = (rem_q != '0);
      e_norm = e_raw - 10'sd1;
    end
  end

  always_comb begin
    inc = 1'b0;
    unique case (rm_q)
      2'b10:   inc = rb & (st | mant[0]);
      2'b11:   inc = rb;
      2'b00:   inc = (rb | st) & ~sign_q;
      default: inc = (rb | st) & sign_q;
    endcase
  end

  assign sum = {1'b0, mant} + {24'h0, inc};

  always_comb begin
    mant_r = sum[23:0];
    e_fin  = e_norm;
    if (sum[24]) begin
      mant_r = 24'h800000;
      e_fin  = e_norm + 10'sd1;
    end
  end

  always_comb begin
    rnd_res = {sign_q, e_fin[7:0], mant_r[22:0]};
    rnd_ovf = 1'b0;
    if (e_fin >= 10'sd255) begin
      rnd_res = {sign_q, 8'hFF, 23'h0};
      rnd_ovf = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      rnd_res = {sign_q, 31'h0};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = DIV;
      DIV: begin
        if (cnt_q == 6'd0 && special)
          state_d = IDLE;
        else if (cnt_q == 6'd25)
          state_d = ROUND;
      end
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      rm_q        <= '0;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      done        <= 1'b0;
      resultDiv   <= '0;
      errorDiv    <= 1'b0;
      overflowDiv <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= A[30:0];
            b_q    <= B[30:0];
            rm_q   <= round_mode;
            sign_q <= A[31] ^ B[31];
            cnt_q  <= '0;
          end
        end
        DIV: begin
          if (cnt_q == 6'd0 && special) begin
            resultDiv   <= spec_res;
            errorDiv    <= spec_err;
            overflowDiv <= 1'b0;
            done        <= 1'b1;
          end else begin
            rem_q <= rem_nx;
            q_q   <= q_nx;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        ROUND: begin
          resultDiv   <= rnd_res;
          errorDiv    <= rnd_ovf;
          overflowDiv <= rnd_ovf;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed cases plus random operands
// compared against an integer-arithmetic reference model.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [1:0]  round_mode = 2'b10;
  logic        busy, done;
  logic [31:0] resultDiv;
  logic        errorDiv, overflowDiv;

  int n_checks = 0;
  int n_errors = 0;

  fp_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .round_mode  (round_mode),
    .busy        (busy),
    .done        (done),
    .resultDiv   (resultDiv),
    .errorDiv    (errorDiv),
    .overflowDiv (overflowDiv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // {special, ovf, err, result}
  function automatic logic [34:0] ref_div(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [1:0]  rm);
    logic s;
    int ea, eb, e;
    longint fa, fb, num, q, r, mant;
    bit na, nb, ia, ib, za, zb, rb, st, inc;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb || (za && zb) || (ia && ib))
      return {3'b101, s, 8'hFF, 23'h400000};
    if (zb && !ia)
      return {3'b101, s, 8'hFF, 23'h0};
    if (ia)
      return {3'b100, s, 8'hFF, 23'h0};
    if (za || ib)
      return {3'b100, s, 31'h0};
    num = ((64'd1 << 23) | fa) << 25;
    q   = num / ((64'd1 << 23) | fb);
    r   = num % ((64'd1 << 23) | fb);
    e   = ea - eb + 127;
    if (q >= (64'd1 << 25)) begin
      mant = q >> 2;
      rb   = q[1];
      st   = q[0] || (r != 0);
    end else begin
      mant = q >> 1;
      rb   = q[0];
      st   = (r != 0);
      e    = e - 1;
    end
    case (rm)
      2'b10:   inc = rb && (st || mant[0]);
      2'b11:   inc = rb;
      2'b00:   inc = (rb || st) && !s;
      default: inc = (rb || st) && s;
    endcase
    mant = mant + longint'(inc);
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e    = e + 1;
    end
    if (e >= 255)
      return {3'b011, s, 8'hFF, 23'h0};
    if (e <= 0)
      return {3'b000, s, 31'h0};
    return {3'b000, s, e[7:0], mant[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [1:0]  rm,
                        input string       tag);
    logic [34:0] exp;
    int lat;
    bit seen;
    exp = ref_div(a, b, rm);
    @(negedge clk);
    A = a;
    B = b;
    round_mode = rm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check({tag, ".seen"}, 64'(seen), 64'd1);
    check({tag, ".lat"}, 64'(lat),
          exp[34] ? 64'd1 : 64'd27);
    check({tag, ".res"}, 64'(resultDiv),
          64'(exp[31:0]));
    check({tag, ".err"}, 64'(errorDiv),
          64'(exp[32]));
    check({tag, ".ovf"}, 64'(overflowDiv),
          64'(exp[33]));
    check({tag, ".idle"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [22:0] f;
    int sel;
    sel = int'($urandom_range(0, 19));
    f   = 23'($urandom);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else if (sel == 2) begin
      e = 8'hFF;
      f = '0;
    end else if (sel < 6)
      e = 8'($urandom_range(1, 30));
    else if (sel < 9)
      e = 8'($urandom_range(225, 254));
    else
      e = 8'($urandom_range(1, 254));
    if (sel == 3) f = '0;
    return {1'($urandom), e, f};
  endfunction

  initial begin
    int dones;
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.res", 64'(resultDiv), 64'd0);
    check("rst.err", 64'(errorDiv), 64'd0);
    check("rst.ovf", 64'(overflowDiv), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h40C00000, 32'h40000000, 2'b10, "six");
    check("six.k", 64'(resultDiv), 64'h40400000);
    run_op(32'h3F800000, 32'h40400000, 2'b10, "third10");
    check("third10.k", 64'(resultDiv), 64'h3EAAAAAB);
    run_op(32'h3F800000, 32'h40400000, 2'b01, "third01");
    check("third01.k", 64'(resultDiv), 64'h3EAAAAAA);
    run_op(32'h3F800000, 32'h40400000, 2'b00, "third00");
    check("third00.k", 64'(resultDiv), 64'h3EAAAAAB);
    run_op(32'h3F800000, 32'h40400000, 2'b11, "third11");
    check("third11.k", 64'(resultDiv), 64'h3EAAAAAB);
    run_op(32'h3F800000, 32'h00000000, 2'b10, "divz");
    check("divz.k", 64'(resultDiv), 64'h7F800000);
    run_op(32'h00000000, 32'h00000000, 2'b10, "zz");
    check("zz.k", 64'(resultDiv), 64'h7FC00000);
    run_op(32'h7F000000, 32'h00800000, 2'b10, "ovf");
    check("ovf.k", 64'(overflowDiv), 64'd1);
    run_op(32'h00800000, 32'h7F000000, 2'b10, "unf");
    check("unf.k", 64'(resultDiv), 64'h0);
    run_op(32'h7F800000, 32'h00000000, 2'b10, "infz");
    run_op(32'hC0000000, 32'h7F800000, 2'b10, "finf");
    run_op(32'h00400000, 32'h3F800000, 2'b10, "subn");

    // a second start while busy must be dropped
    @(negedge clk);
    A = 32'hBF800000;
    B = 32'h3F800000;
    round_mode = 2'b10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    A = 32'h40C00000;
    B = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("ign.dones", 64'(dones), 64'd1);
    check("ign.res", 64'(resultDiv), 64'hBF800000);
    check("ign.busy", 64'(busy), 64'd0);

    // abort mid-operation with reset
    @(negedge clk);
    A = 32'h3F800000;
    B = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.res", 64'(resultDiv), 64'd0);
    check("abort.err", 64'(errorDiv), 64'd0);
    check("abort.ovf", 64'(overflowDiv), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h40C00000, 32'h40000000, 2'b10, "post");

    for (int i = 0; i < 60; i++)
      run_op(rand_op(), rand_op(),
             2'($urandom), $sformatf("rnd%0d", i));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
# fp_divider

Sequential IEEE-754 single-precision divider computing A / B with a radix-2 restoring mantissa loop. It uses the same round-mode encoding, flag semantics and exception style as the combinational multiplier, and is the divide path of the FPU datapath. A start/busy/done handshake replaces the combinational timing, giving a fixed latency of 27 clock edges from an accepted start to a registered result.

## Interface
- No parameters; the format is fixed at binary32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- A  input  32  dividend (binary32).
- B  input  32  divisor (binary32).
- round_mode  input  2  rounding mode: 00 toward +inf, 01 toward -inf, 10 nearest-even, 11 nearest ties-away.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- resultDiv  output  32  quotient, registered and held until the next done.
- errorDiv  output  1  set on invalid operation, divide-by-zero or overflow.
- overflowDiv  output  1  set on exponent overflow.

## Operation
- **Reset:** state IDLE; busy, done, resultDiv, errorDiv and overflowDiv all 0. Asserting rst_n mid-operation aborts the operation with no done pulse.
- **States:** IDLE -> (start) LATCH-decision -> SPECIAL or DIV -> ROUND -> IDLE.
  - IDLE with start=1: latch A, B, round_mode and sign S = A[31]^B[31].
  - Classify the operands. Subnormal inputs (E=0, F!=0) are flushed to zero.
- **Specials** (resolved in one cycle, in this priority):
  - Either operand NaN, 0/0 or inf/inf -> {S, FF, 400000}, errorDiv=1.
  - Finite nonzero / 0 -> {S, FF, 0}, errorDiv=1, overflowDiv=0.
  - inf / finite -> {S, FF, 0}, flags 0.
  - 0 / nonzero or finite / inf -> {S, 00, 0}, flags 0.
- **Normal operands:**
  - Form M1 = {1, F1} and M2 = {1, F2}.
  - Compute E = E1 - E2 + 127 as a 10-bit signed value.
  - DIV runs 26 iterations. Each iteration: rem = rem<<1 (the first uses rem = M1); if rem >= M2, subtract M2 and shift in q=1, else shift in q=0. This builds q[25:0] with q[25] as the integer bit. A 6-bit counter runs 0..25.
- **Normalize:**
  - q[25]=1: mantissa = q[25:2], round bit = q[1], sticky = q[0] | (rem != 0).
  - q[25]=0: mantissa = q[24:1], round bit = q[0], sticky = (rem != 0), E = E - 1.
- **Round increment condition:**
  - 10: round & (sticky | lsb).
  - 11: round.
  - 00: (round | sticky) & ~S.
  - 01: (round | sticky) & S.
  - A carry out of the 24-bit mantissa sets mantissa = 1.0 and E = E + 1.
- **Final check, after rounding:**
  - E >= 255 -> {S, FF, 0}, overflowDiv=1, errorDiv=1.
  - E <= 0 -> {S, 00, 0}, flags 0 (flush to zero, no underflow flag).
  - Otherwise -> {S, E[7:0], mantissa[22:0]}, flags 0.

## Timing
- start is accepted at edge k in IDLE; busy=1 from edge k.
- Special case: result, flags and done=1 are registered at edge k+1; busy=0 at the same edge.
- Normal case:
  - Iterations run on edges k+1..k+26.
  - ROUND registers the result, flags and done=1 at edge k+27; busy=0 at that edge.
- done is high for exactly one cycle and clears at the next edge.
- start while busy=1 is ignored and is not queued.
- start may be asserted in the cycle done=1 (state is IDLE); it is accepted normally.
- resultDiv and the flags change only at a done edge or on reset.

## Test plan
- A=40C00000 (6.0), B=40000000 (2.0), rm=10, start at edge k -> resultDiv=40400000, flags 0, done at edge k+27, busy high for 27 cycles.
- A=3F800000 (1.0), B=40400000 (3.0) -> rm=10: 3EAAAAAB; rm=01: 3EAAAAAA; rm=00: 3EAAAAAB; rm=11: 3EAAAAAB; each with 27-edge latency.
- A=3F800000, B=00000000 -> 7F800000, errorDiv=1, overflowDiv=0, done at k+1. A=0, B=0 -> 7FC00000, errorDiv=1.
- A=7F000000, B=00800000 -> 7F800000, overflowDiv=1, errorDiv=1. A=00800000, B=7F000000 -> 00000000, flags 0.
- A=BF800000, B=3F800000 -> BF800000. A second start pulsed 5 cycles later is ignored; exactly one done is produced.
- Drive rst_n low at iteration 10 -> busy, done, resultDiv and flags are 0 immediately. After release, a new 6.0/2.0 start completes correctly at k+27.
